// File: rtl/evp_pkg.sv
// Shared definitions for the store-polynomial (STP) and evaluate-polynomial (EVP) stages.
package evp_pkg;
  localparam int NUM_POLY       = 8;
  localparam int COEFF_PER_POLY = 11;
  localparam int MAX_N          = 10;
  localparam int A_W            = 3;
  localparam int N_W            = 5;
  localparam int S_AW           = 7;
  localparam int IDX_W          = 5;
  localparam int D_W            = 16;

  localparam logic [N_W-1:0] N_INVALID   = 5'b11111;
  localparam logic [31:0]    STATUS_OK   = 32'd0;
  localparam logic [31:0]    STATUS_ERR  = 32'd2;
  localparam logic [31:0]    STATUS_NONE = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_START, ST_COEFF, ST_WRITE_N, ST_END
  } stp_state_t;

  // Command latched from start_stp.
  typedef struct packed {
    logic [A_W-1:0] a;
    logic [N_W-1:0] n;
    logic           err;
  } stp_cmd_t;

  function automatic logic n_is_invalid(input logic [N_W-1:0] n);
    return n > N_W'(MAX_N);
  endfunction
endpackage

// File: rtl/slot_addr_gen.sv
// Coefficient RAM address for slot/index: slot*COEFF_PER_POLY + idx.
import evp_pkg::*;

module slot_addr_gen (
  input  logic [A_W-1:0]   slot,
  input  logic [IDX_W-1:0] idx,
  output logic [S_AW-1:0]  addr
);
  // Max slot term is 77; even idx=31 stays under 128, so 7 bits never wrap.
  assign addr = S_AW'(slot) * S_AW'(COEFF_PER_POLY) + S_AW'(idx);
endmodule

// File: rtl/stp_fsm_3.sv
// Store-polynomial FSM: drains N+1 FIFO tokens into S RAM, then commits N to the N RAM.
import evp_pkg::*;

module stp_fsm_3 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stp,
  input  logic [2:0]  A,
  input  logic [4:0]  N,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        en_rd_fifo,
  output logic        en_wr_S,
  output logic [6:0]  wr_addr_S,
  output logic [15:0] wr_data_S,
  output logic        en_wr_N,
  output logic [2:0]  wr_addr_N,
  output logic [4:0]  wr_data_N,
  output logic        busy,
  output logic        done_stp,
  output logic [31:0] status
);
  stp_state_t       state;
  stp_cmd_t         cmd;
  logic [IDX_W-1:0] idx;
  logic [3:0]       init_k;
  logic [S_AW-1:0]  addr_s;
  logic             tok;

  slot_addr_gen u_addr (.slot(cmd.a), .idx(idx), .addr(addr_s));

  // The FIFO is first-word-fall-through, so the pop and the S write must
  // follow fifo_empty in the same cycle; these stay combinational.
  assign tok        = (state == ST_COEFF) && !fifo_empty;
  assign en_rd_fifo = tok;
  assign en_wr_S    = tok && !cmd.err;
  assign wr_addr_S  = en_wr_S ? addr_s : '0;
  assign wr_data_S  = en_wr_S ? fifo_data : '0;
  assign busy       = (state != ST_IDLE);

  // State machine; N-RAM port, done and status are registered on entry to the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_k    <= '0;
      cmd       <= '0;
      idx       <= '0;
      en_wr_N   <= 1'b0;
      wr_addr_N <= '0;
      wr_data_N <= '0;
      done_stp  <= 1'b0;
      status    <= STATUS_NONE;
    end else begin
      en_wr_N   <= 1'b0;
      wr_addr_N <= '0;
      wr_data_N <= '0;
      done_stp  <= 1'b0;
      case (state)
        // Invalidate every slot, one per cycle; leave after the last write has been shown.
        ST_INIT: begin
          if (init_k == 4'(NUM_POLY)) begin
            state <= ST_IDLE;
          end else begin
            en_wr_N   <= 1'b1;
            wr_addr_N <= init_k[2:0];
            wr_data_N <= N_INVALID;
            init_k    <= init_k + 4'd1;
          end
        end
        ST_IDLE: begin
          if (start_stp) begin
            cmd.a   <= A;
            cmd.n   <= N;
            cmd.err <= n_is_invalid(N);
            idx     <= '0;
            status  <= STATUS_NONE;
            state   <= ST_START;
          end
        end
        ST_START: state <= ST_COEFF;
        ST_COEFF: begin
          if (!fifo_empty) begin
            idx <= idx + 5'd1;
            if (idx == cmd.n) begin
              state     <= ST_WRITE_N;
              en_wr_N   <= 1'b1;
              wr_addr_N <= cmd.a;
              wr_data_N <= cmd.err ? N_INVALID : cmd.n;
              status    <= cmd.err ? STATUS_ERR : STATUS_OK;
            end
          end
        end
        ST_WRITE_N: begin
          state    <= ST_END;
          done_stp <= 1'b1;
        end
        ST_END:  state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule
